// File: rtl/sdp_bram_fifo_ctrl.sv
// sdp_bram_fifo_ctrl
// Turns one external simple-dual-port block RAM into a valid/ready stream
// FIFO. Upstream words go straight into RAM port A. Reads are issued early on
// port B. The fixed RAM read latency is hidden by a small output buffer. A read
// is only issued when the buffer has a free slot reserved for its data, so
// downstream backpressure never loses a word.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   s_valid/s_ready/s_data      upstream stream (producer side)
//   m_valid/m_ready/m_data      downstream stream (consumer side)
//   level                       words accepted and not yet delivered
//   full                        RAM storage holds DEPTH words
//   empty                       level == 0
//   bram_addra/dina/ena/wea     RAM write port
//   bram_addrb/enb              RAM read port (enb = read issue)
//   bram_oreg_enb, bram_rstb    RAM output register enable / reset
//   bram_doutb                  RAM read data, RD_LATENCY cycles after issue
module sdp_bram_fifo_ctrl #(
   parameter int WIDTH      = 72,
   parameter int DEPTH      = 2048,
   parameter int RD_LATENCY = 2,
   parameter int OBUF_DEPTH = 4,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [AW+1:0]    level,
   output logic             full,
   output logic             empty,
   output logic [AW-1:0]    bram_addra,
   output logic [WIDTH-1:0] bram_dina,
   output logic             bram_ena,
   output logic             bram_wea,
   output logic [AW-1:0]    bram_addrb,
   output logic             bram_enb,
   output logic             bram_oreg_enb,
   output logic             bram_rstb,
   input  logic [WIDTH-1:0] bram_doutb
);

   localparam int OW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int CW = $clog2(OBUF_DEPTH + 2);

   // Reject configurations the credit scheme cannot support at elaboration.
   if ((OBUF_DEPTH < RD_LATENCY + 1) || (RD_LATENCY < 1) || (RD_LATENCY > 2) ||
       (DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_check
      $error("sdp_bram_fifo_ctrl: illegal DEPTH/RD_LATENCY/OBUF_DEPTH combination");
   end

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         bram_cnt;
   logic [AW+1:0]       level_q;
   logic [RD_LATENCY-1:0] rd_pipe;
   logic [WIDTH-1:0]    obuf [OBUF_DEPTH];
   logic [OW-1:0]       obuf_head;
   logic [OW-1:0]       obuf_tail;
   logic [CW-1:0]       obuf_cnt;
   logic [CW-1:0]       inflight;
   logic [CW-1:0]       credits;
   logic                wr_en;
   logic                pop;
   logic                issue;
   logic                capture;

   function automatic logic [OW-1:0] obuf_next(input logic [OW-1:0] p);
      return (p == OW'(OBUF_DEPTH - 1)) ? '0 : p + OW'(1);
   endfunction

   // Reads issued but whose data has not yet reached the output buffer.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CW'(rd_pipe[i]);
      end
   end

   // A slot freed by a pop this cycle can already be promised to a new read,
   // because the data of that read arrives at least one cycle later.
   assign credits = CW'(OBUF_DEPTH) - inflight - obuf_cnt + CW'(pop);

   assign s_ready = !rst && (bram_cnt != (AW+1)'(DEPTH));
   assign wr_en   = s_valid && s_ready;
   assign m_valid = !rst && (obuf_cnt != '0);
   assign pop     = m_valid && m_ready;
   assign issue   = !rst && (bram_cnt != '0) && (credits != '0);
   assign capture = rd_pipe[RD_LATENCY-1];
   assign m_data  = obuf[obuf_head];

   assign bram_ena      = wr_en;
   assign bram_wea      = wr_en;
   assign bram_addra    = wr_ptr;
   assign bram_dina     = s_data;
   assign bram_enb      = issue;
   assign bram_addrb    = rd_ptr;
   assign bram_oreg_enb = 1'b1;
   assign bram_rstb     = rst;

   assign level = level_q;
   assign empty = rst || (level_q == '0);
   assign full  = !rst && (bram_cnt == (AW+1)'(DEPTH));

   // Pointers, occupancy counters and the read-valid pipe. Reset drops every
   // stored and in-flight word; RAM contents are simply forgotten.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         bram_cnt  <= '0;
         level_q   <= '0;
         rd_pipe   <= '0;
         obuf_head <= '0;
         obuf_tail <= '0;
         obuf_cnt  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (issue) rd_ptr <= rd_ptr + AW'(1);

         case ({wr_en, issue})
            2'b10:   bram_cnt <= bram_cnt + (AW+1)'(1);
            2'b01:   bram_cnt <= bram_cnt - (AW+1)'(1);
            default: bram_cnt <= bram_cnt;
         endcase

         case ({wr_en, pop})
            2'b10:   level_q <= level_q + (AW+2)'(1);
            2'b01:   level_q <= level_q - (AW+2)'(1);
            default: level_q <= level_q;
         endcase

         rd_pipe[0] <= issue;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end

         if (capture) obuf_tail <= obuf_next(obuf_tail);
         if (pop)     obuf_head <= obuf_next(obuf_head);

         case ({capture, pop})
            2'b10:   obuf_cnt <= obuf_cnt + CW'(1);
            2'b01:   obuf_cnt <= obuf_cnt - CW'(1);
            default: obuf_cnt <= obuf_cnt;
         endcase
      end
   end

   // Output buffer storage needs no reset; validity lives in obuf_cnt.
   always_ff @(posedge clk) begin
      if (capture && !rst) obuf[obuf_tail] <= bram_doutb;
   end

   // Credits make a capture into a full, non-draining buffer impossible.
   a_obuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(capture && !pop && (obuf_cnt == CW'(OBUF_DEPTH))));

endmodule

// File: tb/tb_sdp_bram_fifo_ctrl.sv
// Testbench for sdp_bram_fifo_ctrl. Two instances share one stimulus:
// u0 uses the default configuration (RD_LATENCY=2, DEPTH=2048, OBUF_DEPTH=4)
// and u1 uses a small configuration (RD_LATENCY=1, DEPTH=16, OBUF_DEPTH=3).
// Each instance has its own behavioural SDP RAM. A scoreboard holds the
// accepted words in order and is compared against both instances every cycle.
module tb_sdp_bram_fifo_ctrl;

   localparam int W  = 72;
   localparam int D0 = 2048;
   localparam int L0 = 2;
   localparam int O0 = 4;
   localparam int A0 = 11;
   localparam int D1 = 16;
   localparam int L1 = 1;
   localparam int O1 = 3;
   localparam int A1 = 4;
   localparam int HN = 32768;

   logic clk = 1'b0;
   logic rst;
   logic s_valid;
   logic m_ready;
   logic [W-1:0] s_data;

   logic s_ready0, m_valid0, full0, empty0, ena0, wea0, enb0, oreg0, rstb0;
   logic [W-1:0] m_data0, dina0, dout0, ram0_q;
   logic [A0+1:0] level0;
   logic [A0-1:0] addra0, addrb0;
   logic [W-1:0] mem0 [0:D0-1];

   logic s_ready1, m_valid1, full1, empty1, ena1, wea1, enb1, oreg1, rstb1;
   logic [W-1:0] m_data1, dina1, dout1;
   logic [A1+1:0] level1;
   logic [A1-1:0] addra1, addrb1;
   logic [W-1:0] mem1 [0:D1-1];

   always #5 clk = ~clk;

   sdp_bram_fifo_ctrl #(.WIDTH(W), .DEPTH(D0), .RD_LATENCY(L0), .OBUF_DEPTH(O0)) u0 (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
      .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
      .level(level0), .full(full0), .empty(empty0),
      .bram_addra(addra0), .bram_dina(dina0), .bram_ena(ena0), .bram_wea(wea0),
      .bram_addrb(addrb0), .bram_enb(enb0), .bram_oreg_enb(oreg0), .bram_rstb(rstb0),
      .bram_doutb(dout0)
   );

   sdp_bram_fifo_ctrl #(.WIDTH(W), .DEPTH(D1), .RD_LATENCY(L1), .OBUF_DEPTH(O1)) u1 (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
      .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
      .level(level1), .full(full1), .empty(empty1),
      .bram_addra(addra1), .bram_dina(dina1), .bram_ena(ena1), .bram_wea(wea1),
      .bram_addrb(addrb1), .bram_enb(enb1), .bram_oreg_enb(oreg1), .bram_rstb(rstb1),
      .bram_doutb(dout1)
   );

   // RAM for u0: read register plus output register (two-cycle read).
   always @(posedge clk) begin
      if (ena0 && wea0) mem0[addra0] <= dina0;
      if (enb0) ram0_q <= mem0[addrb0];
      if (rstb0) dout0 <= '0;
      else if (oreg0) dout0 <= ram0_q;
   end

   // RAM for u1: single read register (one-cycle read).
   always @(posedge clk) begin
      if (ena1 && wea1) mem1[addra1] <= dina1;
      if (rstb1) dout1 <= '0;
      else if (enb1) dout1 <= mem1[addrb1];
   end

   int checks = 0;
   int failures = 0;

   logic [W-1:0] hist [2][0:HN-1];
   int wr_n [2];
   int rd_n [2];
   logic prev_stall [2];
   logic [W-1:0] prev_data [2];

   logic sr [2];
   logic mv [2];
   logic fl [2];
   logic em [2];
   logic [W-1:0] md [2];
   int lv [2];

   always_comb begin
      sr[0] = s_ready0; mv[0] = m_valid0; fl[0] = full0; em[0] = empty0;
      md[0] = m_data0;  lv[0] = int'(level0);
      sr[1] = s_ready1; mv[1] = m_valid1; fl[1] = full1; em[1] = empty1;
      md[1] = m_data1;  lv[1] = int'(level1);
   end

   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Drives the inputs for the next clock cycle, just after the rising edge.
   task automatic applyStimulus(input logic r, input logic sv, input logic [W-1:0] sd,
                                input logic mr);
      @(posedge clk);
      #1;
      rst = r;
      s_valid = sv;
      s_data = sd;
      m_ready = mr;
   endtask

   task automatic drainAll(input int budget);
      int n;
      n = 0;
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      while (!(empty0 && empty1) && n < budget) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b1);
         @(negedge clk);
         n++;
      end
      checkValue("drain_empty", int'(empty0 && empty1), 1);
   endtask

   // Scoreboard compare: mid-cycle, inputs are settled and the handshakes of
   // the coming edge are known.
   always @(negedge clk) begin
      int dep;
      int cap;
      int mlev;
      for (int k = 0; k < 2; k++) begin
         dep = (k == 0) ? D0 : D1;
         cap = (k == 0) ? D0 + O0 : D1 + O1;
         if (rst) begin
            checkValue($sformatf("rst_m_valid%0d", k), int'(mv[k]), 0);
            checkValue($sformatf("rst_s_ready%0d", k), int'(sr[k]), 0);
            checkValue($sformatf("rst_empty%0d", k), int'(em[k]), 1);
            checkValue($sformatf("rst_full%0d", k), int'(fl[k]), 0);
            rd_n[k] = wr_n[k];
            prev_stall[k] = 1'b0;
         end else begin
            mlev = wr_n[k] - rd_n[k];
            checkValue($sformatf("level%0d", k), lv[k], mlev);
            checkValue($sformatf("empty%0d", k), int'(em[k]), int'(mlev == 0));
            checkValue($sformatf("s_ready_vs_full%0d", k), int'(sr[k]), int'(!fl[k]));
            if (mlev < dep) checkValue($sformatf("full_early%0d", k), int'(fl[k]), 0);
            if (mlev >= cap) checkValue($sformatf("s_ready_at_cap%0d", k), int'(sr[k]), 0);
            if (mlev == 0) checkValue($sformatf("m_valid_when_empty%0d", k), int'(mv[k]), 0);
            if (mv[k]) checkOutput($sformatf("m_data_order%0d", k), md[k], hist[k][rd_n[k] % HN]);
            if (prev_stall[k]) begin
               checkValue($sformatf("stall_valid%0d", k), int'(mv[k]), 1);
               checkOutput($sformatf("stall_data%0d", k), md[k], prev_data[k]);
            end
            if (s_valid && sr[k]) begin
               hist[k][wr_n[k] % HN] = s_data;
               wr_n[k]++;
            end
            if (mv[k] && m_ready) rd_n[k]++;
            prev_stall[k] = mv[k] && !m_ready;
            prev_data[k] = md[k];
         end
      end
   end

   initial begin
      int gaps0, gaps1, acc0, acc1, ecnt0, ecnt1, n;
      logic [W-1:0] rv;
      for (int k = 0; k < 2; k++) begin
         wr_n[k] = 0; rd_n[k] = 0; prev_stall[k] = 1'b0; prev_data[k] = '0;
      end
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

      // Reset state
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkValue("reset_m_valid0", int'(m_valid0), 0);
      checkValue("reset_empty0", int'(empty0), 1);
      checkValue("reset_full0", int'(full0), 0);
      checkValue("reset_s_ready0", int'(s_ready0), 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkValue("after_reset_level0", int'(level0), 0);
      checkValue("after_reset_s_ready0", int'(s_ready0), 1);
      repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);

      // Single word latency: write in cycle t, u0 valid at t+4, u1 at t+3
      applyStimulus(1'b0, 1'b1, W'(72'hA5), 1'b1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkValue("lat_t1_level0", int'(level0), 1);
      checkValue("lat_t1_m_valid0", int'(m_valid0), 0);
      checkValue("lat_t1_m_valid1", int'(m_valid1), 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkValue("lat_t2_m_valid0", int'(m_valid0), 0);
      checkValue("lat_t2_m_valid1", int'(m_valid1), 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkValue("lat_t3_m_valid0", int'(m_valid0), 0);
      checkValue("lat_t3_m_valid1", int'(m_valid1), 1);
      checkOutput("lat_t3_m_data1", m_data1, W'(72'hA5));
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkValue("lat_t4_m_valid0", int'(m_valid0), 1);
      checkOutput("lat_t4_m_data0", m_data0, W'(72'hA5));
      checkValue("lat_t4_level0", int'(level0), 1);
      checkValue("lat_t4_empty1", int'(empty1), 1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      checkValue("lat_t5_level0", int'(level0), 0);
      checkValue("lat_t5_empty0", int'(empty0), 1);

      // Sustained stream: one word per cycle, u0 pointers wrap twice
      gaps0 = 0; gaps1 = 0;
      for (int i = 0; i < 5000; i++) begin
         applyStimulus(1'b0, 1'b1, W'(i) + W'(72'h1000), 1'b1);
         @(negedge clk);
         if (i >= L0 + 2 && !m_valid0) gaps0++;
         if (i >= L1 + 2 && !m_valid1) gaps1++;
      end
      checkValue("stream_gaps0", gaps0, 0);
      checkValue("stream_gaps1", gaps1, 0);
      drainAll(50);

      // Fill with the consumer stalled until both instances refuse input
      acc0 = 0; acc1 = 0; ecnt0 = 0; ecnt1 = 0; n = 0;
      applyStimulus(1'b0, 1'b1, W'(72'h20000), 1'b0);
      @(negedge clk);
      while ((s_ready0 || s_ready1) && n < 2200) begin
         if (s_ready0) acc0++;
         if (s_ready1) acc1++;
         if (enb0) ecnt0++;
         if (enb1) ecnt1++;
         applyStimulus(1'b0, 1'b1, s_data + W'(1), 1'b0);
         @(negedge clk);
         n++;
      end
      if (enb0) ecnt0++;
      if (enb1) ecnt1++;
      checkValue("fill_accepted0", acc0, 2052);
      checkValue("fill_accepted1", acc1, 19);
      checkValue("fill_full0", int'(full0), 1);
      checkValue("fill_full1", int'(full1), 1);
      checkValue("fill_level0", int'(level0), 2052);
      checkValue("fill_level1", int'(level1), 19);
      checkValue("fill_read_issues0", ecnt0, 4);
      checkValue("fill_read_issues1", ecnt1, 3);
      checkOutput("fill_head0", m_data0, W'(72'h20000));
      drainAll(2300);

      // Random valid/ready toggling
      for (int i = 0; i < 6000; i++) begin
         rv = {8'($urandom), $urandom, $urandom};
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), rv, 1'($urandom_range(0, 1)));
      end
      drainAll(2300);

      // Simultaneous write and pop with one word stored
      applyStimulus(1'b0, 1'b1, W'(72'h5A5A), 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkValue("wp_pre_level0", int'(level0), 1);
      checkValue("wp_pre_level1", int'(level1), 1);
      applyStimulus(1'b0, 1'b1, W'(72'h6B6B), 1'b1);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkValue("wp_level0", int'(level0), 1);
      checkValue("wp_level1", int'(level1), 1);
      repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkValue("wp_m_valid0", int'(m_valid0), 1);
      checkOutput("wp_m_data0", m_data0, W'(72'h6B6B));
      checkOutput("wp_m_data1", m_data1, W'(72'h6B6B));
      drainAll(20);

      // Reset mid-operation with reads in flight
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, W'(72'h300) + W'(i), 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkValue("mid_reset_m_valid0", int'(m_valid0), 0);
      checkValue("mid_reset_level0", int'(level0), 0);
      checkValue("mid_reset_empty0", int'(empty0), 1);
      checkValue("mid_reset_m_valid1", int'(m_valid1), 0);
      checkValue("mid_reset_level1", int'(level1), 0);
      repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkValue("late_data_m_valid0", int'(m_valid0), 0);
      checkValue("late_data_m_valid1", int'(m_valid1), 0);
      applyStimulus(1'b0, 1'b1, W'(72'h1), 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      checkValue("post_reset_m_valid0", int'(m_valid0), 1);
      checkOutput("post_reset_first0", m_data0, W'(72'h1));
      checkOutput("post_reset_first1", m_data1, W'(72'h1));
      drainAll(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
